// File: rtl/mvu_pkg.sv
// -----------------------------------------------------------------------------
// mvu_pkg -- shared constants and types for the MVU address generators.
//
// Contents:
//   BPREC, BDBANKA, BDBANKW, BWLENGTH : field / bus widths
//   agu_state_e                       : IDLE / RUN / DRAIN job states
//   agu_cfg_t                         : job configuration latched on start
// -----------------------------------------------------------------------------
package mvu_pkg;

  localparam int BPREC    = 6;   // precision field width
  localparam int BDBANKA  = 15;  // data memory address width
  localparam int BDBANKW  = 64;  // data memory word width
  localparam int BWLENGTH = 8;   // loop length field width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } agu_state_e;

  // Index [0] is the innermost strided loop level.
  typedef struct packed {
    logic [BPREC-1:0]             prec_m1;  // bit-planes minus one (0 => 1 plane)
    logic [BDBANKA-1:0]           base;
    logic [2:0][BDBANKA-1:0]      stride;
    logic [2:0][BWLENGTH-1:0]     len;      // iteration count minus one
  } agu_cfg_t;

  // A precision of 0 is treated as a single bit-plane.
  function automatic logic [BPREC-1:0] prec_to_max(input logic [BPREC-1:0] prec);
    return (prec == '0) ? '0 : prec - 1'b1;
  endfunction

endpackage

// File: rtl/outagu_if.sv
// -----------------------------------------------------------------------------
// outagu_if -- result-word stream in, data-memory write request out.
//
// Signals:
//   in_valid / in_data / in_ready   : bit-plane word stream from the serializer
//   wr_req / wr_addr / wr_data      : write request toward the memory arbiter
//   wr_grant                        : arbiter takes the request this cycle
//
// Modports:
//   slave  : the address generator (consumes words, issues requests)
//   master : the environment (produces words, grants requests)
// -----------------------------------------------------------------------------
interface outagu_if;

  logic                        in_valid;
  logic [mvu_pkg::BDBANKW-1:0] in_data;
  logic                        in_ready;
  logic                        wr_req;
  logic [mvu_pkg::BDBANKA-1:0] wr_addr;
  logic [mvu_pkg::BDBANKW-1:0] wr_data;
  logic                        wr_grant;

  modport slave (
    input  in_valid, in_data, wr_grant,
    output in_ready, wr_req, wr_addr, wr_data
  );

  modport master (
    output in_valid, in_data, wr_grant,
    input  in_ready, wr_req, wr_addr, wr_data
  );

endinterface

// File: rtl/outagu_loopctr.sv
// -----------------------------------------------------------------------------
// outagu_loopctr -- bit-plane counter nested inside a 3-level strided loop.
//
// Produces the offset acc = b + i0*stride0 + i1*stride1 + i2*stride2 without
// multipliers: each loop level keeps a running partial sum that is advanced by
// its stride and reloaded from the next-outer partial sum on carry.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   clear_i      : zero all counters (job start)
//   step_i       : advance one word (innermost first)
//   prec_m1_i    : last bit-plane index
//   len_i[2:0]   : last iteration index per level
//   stride_i[2:0]: address stride per level
//   last_o       : current position is the final one of the job
//   acc_o        : current offset (modulo 2^BDBANKA)
// -----------------------------------------------------------------------------
module outagu_loopctr
  import mvu_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_i,
  input  logic                         step_i,
  input  logic [BPREC-1:0]             prec_m1_i,
  input  logic [2:0][BWLENGTH-1:0]     len_i,
  input  logic [2:0][BDBANKA-1:0]      stride_i,
  output logic                         last_o,
  output logic [BDBANKA-1:0]           acc_o
);

  logic [BPREC-1:0]    b_q, b_d;
  logic [BWLENGTH-1:0] i0_q, i0_d, i1_q, i1_d, i2_q, i2_d;
  // Partial sums: lvl0 = i0*s0+i1*s1+i2*s2, lvl1 = i1*s1+i2*s2, lvl2 = i2*s2.
  logic [BDBANKA-1:0]  lvl0_q, lvl0_d, lvl1_q, lvl1_d, lvl2_q, lvl2_d;

  logic b_max, i0_max, i1_max, i2_max;

  assign b_max  = (b_q  == prec_m1_i);
  assign i0_max = (i0_q == len_i[0]);
  assign i1_max = (i1_q == len_i[1]);
  assign i2_max = (i2_q == len_i[2]);

  assign last_o = b_max & i0_max & i1_max & i2_max;
  assign acc_o  = lvl0_q + BDBANKA'(b_q);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through the branches below can leave one unassigned and infer a latch.
    b_d    = b_q;
    i0_d   = i0_q;
    i1_d   = i1_q;
    i2_d   = i2_q;
    lvl0_d = lvl0_q;
    lvl1_d = lvl1_q;
    lvl2_d = lvl2_q;

    if (clear_i) begin
      b_d    = '0;
      i0_d   = '0;
      i1_d   = '0;
      i2_d   = '0;
      lvl0_d = '0;
      lvl1_d = '0;
      lvl2_d = '0;
    end else if (step_i) begin
      if (!b_max) begin
        b_d = b_q + 1'b1;
      end else begin
        b_d = '0;
        if (!i0_max) begin
          i0_d   = i0_q + 1'b1;
          lvl0_d = lvl0_q + stride_i[0];
        end else begin
          i0_d = '0;
          if (!i1_max) begin
            i1_d   = i1_q + 1'b1;
            lvl1_d = lvl1_q + stride_i[1];
            lvl0_d = lvl1_q + stride_i[1];
          end else begin
            i1_d = '0;
            if (!i2_max) begin
              i2_d   = i2_q + 1'b1;
              lvl2_d = lvl2_q + stride_i[2];
              lvl1_d = lvl2_q + stride_i[2];
              lvl0_d = lvl2_q + stride_i[2];
            end else begin
              // Whole job consumed: return to the origin.
              i2_d   = '0;
              lvl0_d = '0;
              lvl1_d = '0;
              lvl2_d = '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from the values
    // that existed before this edge, independent of statement order.
    if (!rst_n) begin
      b_q    <= '0;
      i0_q   <= '0;
      i1_q   <= '0;
      i2_q   <= '0;
      lvl0_q <= '0;
      lvl1_q <= '0;
      lvl2_q <= '0;
    end else begin
      b_q    <= b_d;
      i0_q   <= i0_d;
      i1_q   <= i1_d;
      i2_q   <= i2_d;
      lvl0_q <= lvl0_d;
      lvl1_q <= lvl1_d;
      lvl2_q <= lvl2_d;
    end
  end

endmodule

// File: rtl/outagu.sv
// -----------------------------------------------------------------------------
// outagu -- write-back address generator for MVU results.
//
// Takes bit-plane words from the serializer, tags each with
// base + b + i0*stride0 + i1*stride1 + i2*stride2 and presents it as a
// registered write request that is held until the arbiter grants it. A grant
// and a new accept in the same cycle replace the request with no bubble.
//
// Ports:
//   clk, rst_n                : clock, synchronous active-low reset
//   start                     : begin a job (only honoured when idle)
//   oprecision                : bit-planes per element (0 => 1)
//   obaseaddr                 : job base address
//   ostride0/1/2, olength0/1/2: loop strides and iteration counts minus one
//   bus (outagu_if.slave)     : word stream in, write request out
//   busy                      : job in progress
//   done                      : one-cycle pulse after the final grant
//   stall_cnt                 : (OUTAGU_STALLCNT_EN only) cycles with a
//                               request pending but not granted, saturating
//
// Build option: define OUTAGU_STALLCNT_EN to add the stall counter.
// -----------------------------------------------------------------------------
module outagu
  import mvu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BPREC-1:0]    oprecision,
  input  logic [BDBANKA-1:0]  obaseaddr,
  input  logic [BDBANKA-1:0]  ostride0,
  input  logic [BDBANKA-1:0]  ostride1,
  input  logic [BDBANKA-1:0]  ostride2,
  input  logic [BWLENGTH-1:0] olength0,
  input  logic [BWLENGTH-1:0] olength1,
  input  logic [BWLENGTH-1:0] olength2,
  outagu_if.slave             bus,
  output logic                busy,
  output logic                done
`ifdef OUTAGU_STALLCNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  agu_state_e         state_q, state_d;
  agu_cfg_t           cfg_q, cfg_d;
  logic               wr_req_q, wr_req_d;
  logic [BDBANKA-1:0] wr_addr_q, wr_addr_d;
  logic [BDBANKW-1:0] wr_data_q, wr_data_d;
  logic               done_q, done_d;

  logic               start_ok;
  logic               in_ready;
  logic               accept;
  logic               lc_last;
  logic [BDBANKA-1:0] lc_acc;

  assign start_ok = (state_q == IDLE) & start;

  // One-entry output register: a new word may enter when it is empty or
  // being drained by a grant in this same cycle.
  assign in_ready = (state_q == RUN) & (!wr_req_q | bus.wr_grant);
  assign accept   = bus.in_valid & in_ready;

  outagu_loopctr u_loopctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (start_ok),
    .step_i    (accept),
    .prec_m1_i (cfg_q.prec_m1),
    .len_i     (cfg_q.len),
    .stride_i  (cfg_q.stride),
    .last_o    (lc_last),
    .acc_o     (lc_acc)
  );

  // Configuration capture.
  always_comb begin
    cfg_d = cfg_q;
    if (start_ok) begin
      cfg_d.prec_m1 = prec_to_max(oprecision);
      cfg_d.base    = obaseaddr;
      cfg_d.stride  = {ostride2, ostride1, ostride0};
      cfg_d.len     = {olength2, olength1, olength0};
    end
  end

  // Job FSM.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && lc_last) state_d = DRAIN;
      DRAIN: begin
        if (bus.wr_grant) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write request register.
  always_comb begin
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (accept) begin
      wr_req_d  = 1'b1;
      wr_addr_d = cfg_q.base + lc_acc;
      wr_data_d = bus.in_data;
    end else if (bus.wr_grant) begin
      wr_req_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.wr_req   = wr_req_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

`ifdef OUTAGU_STALLCNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts only while a job is active; keeps its value once the job ends.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_ok) begin
      stall_cnt_d = '0;
    end else if ((state_q != IDLE) && wr_req_q && !bus.wr_grant &&
                 (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_outagu.sv
// -----------------------------------------------------------------------------
// tb_outagu -- directed self-checking bench for outagu.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge or 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_outagu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  oprecision;
  logic [14:0] obaseaddr, ostride0, ostride1, ostride2;
  logic [7:0]  olength0, olength1, olength2;
  logic        busy, done;
`ifdef OUTAGU_STALLCNT_EN
  logic [31:0] stall_cnt;
`endif

  outagu_if bus ();

  outagu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .oprecision (oprecision),
    .obaseaddr  (obaseaddr),
    .ostride0   (ostride0),
    .ostride1   (ostride1),
    .ostride2   (ostride2),
    .olength0   (olength0),
    .olength1   (olength1),
    .olength2   (olength2),
    .bus        (bus),
    .busy       (busy),
    .done       (done)
`ifdef OUTAGU_STALLCNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Granted writes, done pulses and their timing.
  logic [14:0] wa_q[$];
  logic [63:0] wd_q[$];
  logic [14:0] exp_a[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          grant_cyc = 0;

  always @(negedge clk) begin
    if (rst_n && bus.wr_req && bus.wr_grant) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      grant_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] pat(input int t, input int i);
    return {8'hD0, t[7:0], 32'h0000_0000, i[15:0]};
  endfunction

  task automatic do_start(input logic [5:0] p, input logic [14:0] base,
                          input logic [14:0] s0, input logic [14:0] s1, input logic [14:0] s2,
                          input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2);
    oprecision = p;  obaseaddr = base;
    ostride0 = s0;   ostride1 = s1;  ostride2 = s2;
    olength0 = l0;   olength1 = l1;  olength2 = l2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // Streams nwords words; grant is withheld for stall_len cycles from cycle
  // stall_at; a competing start is pulsed at cycle restart_at.
  task automatic run_job(input int nwords, input int tagv, input int stall_at,
                         input int stall_len, input int restart_at);
    int   sent = 0;
    int   c    = 0;
    logic acc;
    bus.in_valid = 1'b1;
    bus.in_data  = pat(tagv, 0);
    while (sent < nwords && c < 200) begin
      bus.wr_grant = !(c >= stall_at && c < stall_at + stall_len);
      if (c == restart_at) begin
        start     = 1'b1;
        obaseaddr = 15'h0700;
      end
      @(negedge clk);
      if (!bus.wr_grant) begin
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_wr_req",   bus.wr_req, 1);
        check("stall_wr_addr",  bus.wr_addr, exp_a[stall_at-1]);
        check("stall_wr_data",  bus.wr_data, pat(tagv, stall_at-1));
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) begin
        sent++;
        bus.in_data = pat(tagv, sent);
      end
      c++;
    end
    bus.in_valid = 1'b0;
    bus.wr_grant = 1'b1;
    check("words_accepted", sent, nwords);
  endtask

  task automatic wait_done(input int d0);
    int c = 0;
    while (done_cnt == d0 && c < 20) begin
      @(negedge clk); #1;
      c++;
    end
    check("done_seen", done_cnt - d0, 1);
    check("done_after_grant", done_cyc - grant_cyc, 1);
    check("busy_at_done", busy, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
  endtask

  task automatic check_writes(input string name, input int tagv);
    check({name, "_count"}, wa_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), wa_q[i], exp_a[i]);
      check($sformatf("%s_data%0d", name, i), wd_q[i], pat(tagv, i));
    end
    wa_q.delete();
    wd_q.delete();
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;  start = 1'b0;
    oprecision = '0; obaseaddr = '0;
    ostride0 = '0; ostride1 = '0; ostride2 = '0;
    olength0 = '0; olength1 = '0; olength2 = '0;
    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.wr_grant = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    check("rst_wr_req",   bus.wr_req, 0);
    check("rst_wr_addr",  bus.wr_addr, 0);
    check("rst_wr_data",  bus.wr_data, 0);
    check("rst_busy",     busy, 0);
    check("rst_done",     done, 0);
    check("rst_in_ready", bus.in_ready, 0);
`ifdef OUTAGU_STALLCNT_EN
    check("rst_stall_cnt", stall_cnt, 0);
`endif

    // Words offered while idle are not taken.
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    check("idle_wr_req", bus.wr_req, 0);
    bus.in_valid = 1'b0;

    // Basic: 2 planes x 3 iterations.
    exp_a = {15'h100, 15'h101, 15'h110, 15'h111, 15'h120, 15'h121};
    do_start(6'd2, 15'h100, 15'h010, 15'h005, 15'h007, 8'd2, 8'd0, 8'd0);
    d0 = done_cnt;
    run_job(6, 1, -10, 0, -10);
    wait_done(d0);
    check_writes("basic", 1);
`ifdef OUTAGU_STALLCNT_EN
    check("basic_stall_cnt", stall_cnt, 0);
`endif

    // Nested: all three loop levels carry.
    exp_a = {15'h000, 15'h001, 15'h020, 15'h021, 15'h400, 15'h401, 15'h420, 15'h421};
    do_start(6'd1, 15'h000, 15'h001, 15'h020, 15'h400, 8'd1, 8'd1, 8'd1);
    d0 = done_cnt;
    run_job(8, 2, -10, 0, -10);
    wait_done(d0);
    check_writes("nested", 2);

    // Backpressure: grant withheld for 3 cycles while word 2 is pending.
    exp_a = {15'h200, 15'h202, 15'h204, 15'h206, 15'h208, 15'h20A};
    do_start(6'd1, 15'h200, 15'h002, 15'h000, 15'h000, 8'd5, 8'd0, 8'd0);
    d0 = done_cnt;
    run_job(6, 3, 3, 3, -10);
    wait_done(d0);
    check_writes("bp", 3);
`ifdef OUTAGU_STALLCNT_EN
    check("bp_stall_cnt", stall_cnt, 3);
`endif

    // Address wrap with precision 0.
    exp_a = {15'h7FFF, 15'h0000};
    do_start(6'd0, 15'h7FFF, 15'h001, 15'h000, 15'h000, 8'd1, 8'd0, 8'd0);
    d0 = done_cnt;
    run_job(2, 4, -10, 0, -10);
    wait_done(d0);
    check_writes("wrap", 4);

    // Reset mid-job with a request pending.
    do_start(6'd1, 15'h300, 15'h001, 15'h000, 15'h000, 8'd7, 8'd0, 8'd0);
    run_job(3, 5, -10, 0, -10);
    check("pre_rst_wr_req",  bus.wr_req, 1);
    check("pre_rst_wr_addr", bus.wr_addr, 15'h302);
    bus.wr_grant = 1'b0;
    bus.in_valid = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_wr_req",   bus.wr_req, 0);
    check("mid_rst_busy",     busy, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    bus.wr_grant = 1'b1;
    // Reset and start in the same cycle: reset wins.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst_n = 1'b1;
    check("rst_and_start_busy", busy, 0);
    wa_q.delete();
    wd_q.delete();

    exp_a = {15'h500, 15'h504};
    do_start(6'd1, 15'h500, 15'h004, 15'h000, 15'h000, 8'd1, 8'd0, 8'd0);
    d0 = done_cnt;
    run_job(2, 6, -10, 0, -10);
    wait_done(d0);
    check_writes("after_rst", 6);

    // A start while busy is ignored.
    exp_a = {15'h600, 15'h601, 15'h602, 15'h603};
    do_start(6'd1, 15'h600, 15'h001, 15'h000, 15'h000, 8'd3, 8'd0, 8'd0);
    d0 = done_cnt;
    run_job(4, 7, -10, 0, 1);
    wait_done(d0);
    check_writes("restart", 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
